sargantana_icache_refill: RTL and testbench

Instruction-cache refill line assembler, sitting directly upstream of the icache way array. It accepts one refill request per miss and collects the fixed-order memory response beats into a full line register. It then issues a single write of that line into the way storage, holding the write until the array arbiter grants it. It reports completion, or an error if any beat was errored, back to the icache controller.

---
 rtl/sargantana_icache_pkg.sv | 17 +
 rtl/sargantana_icache_line_buffer.sv | 29 ++
 rtl/sargantana_icache_refill.sv | 166 ++++++++++++++++
 tb/tb_sargantana_icache_refill.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sargantana_icache_pkg.sv
// Shared icache refill constants and the refill FSM state type.
package sargantana_icache_pkg;

    localparam int SET_WIDHT           = 256;
    localparam int ADDR_WIDHT          = 7;
    localparam int BEAT_WIDTH          = 64;
    localparam int ICACHE_REFILL_BEATS = SET_WIDHT / BEAT_WIDTH;
    localparam int ICACHE_REFILL_CNT_W = $clog2(ICACHE_REFILL_BEATS);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE
    } refill_state_e;

endpackage

// File: rtl/sargantana_icache_line_buffer.sv
// Beat-indexed line register; exposes the assembled line with beat 0 in the low bits.
module sargantana_icache_line_buffer
    import sargantana_icache_pkg::*;
#(
    parameter int LB_BEATS  = ICACHE_REFILL_BEATS,
    parameter int LB_BEAT_W = BEAT_WIDTH,
    parameter int LB_IDX_W  = ICACHE_REFILL_CNT_W
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          we_i,
    input  logic [LB_IDX_W-1:0]           idx_i,
    input  logic [LB_BEAT_W-1:0]          data_i,
    output logic [LB_BEATS*LB_BEAT_W-1:0] line_o
);

    logic [LB_BEATS-1:0][LB_BEAT_W-1:0] r_line;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_line <= '0;
        end else if (we_i) begin
            r_line[idx_i] <= data_i;
        end
    end

    assign line_o = r_line;

endmodule

// File: rtl/sargantana_icache_refill.sv
// Icache refill line assembler: collects response beats, writes the line, reports done/err.
// Critical-beat forwarding is built only when SARGANTANA_ICACHE_CRITICAL_FWD_EN is defined.
module sargantana_icache_refill
    import sargantana_icache_pkg::*;
#(
    parameter int SET_WIDHT  = sargantana_icache_pkg::SET_WIDHT,
    parameter int BEAT_WIDTH = sargantana_icache_pkg::BEAT_WIDTH,
    parameter int ADDR_WIDHT = sargantana_icache_pkg::ADDR_WIDHT
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   refill_valid_i,
    output logic                                   refill_ready_o,
    input  logic [ADDR_WIDHT-1:0]                  refill_idx_i,
    input  logic [$clog2(SET_WIDHT/BEAT_WIDTH)-1:0] refill_word_i,
    input  logic                                   beat_valid_i,
    output logic                                   beat_ready_o,
    input  logic [BEAT_WIDTH-1:0]                  beat_data_i,
    input  logic                                   beat_err_i,
    output logic                                   way_req_o,
    output logic                                   way_we_o,
    output logic [ADDR_WIDHT-1:0]                  way_addr_o,
    output logic [SET_WIDHT-1:0]                   way_data_o,
    input  logic                                   way_gnt_i,
    output logic                                   done_o,
    output logic                                   err_o,
    output logic                                   fwd_valid_o,
    output logic [BEAT_WIDTH-1:0]                  fwd_data_o
);

    localparam int N     = SET_WIDHT / BEAT_WIDTH;
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    refill_state_e         r_state;
    logic                  r_refill_ready;
    logic                  r_beat_ready;
    logic                  r_way_req;
    logic                  r_done;
    logic                  r_err;
    logic                  r_err_flag;
    logic [ADDR_WIDHT-1:0] r_idx;
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_req_hs;
    logic                  w_beat_hs;
    logic                  w_err_next;

    assign w_req_hs   = refill_valid_i & r_refill_ready;
    assign w_beat_hs  = beat_valid_i & r_beat_ready;
    assign w_err_next = r_err_flag | beat_err_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= IDLE;
            r_refill_ready <= 1'b0;
            r_beat_ready   <= 1'b0;
            r_way_req      <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
            r_err_flag     <= 1'b0;
            r_idx          <= '0;
            r_cnt          <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_refill_ready <= 1'b1;
                    if (w_req_hs) begin
                        r_idx          <= refill_idx_i;
                        r_cnt          <= '0;
                        r_err_flag     <= 1'b0;
                        r_refill_ready <= 1'b0;
                        r_beat_ready   <= 1'b1;
                        r_state        <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (w_beat_hs) begin
                        r_cnt      <= r_cnt + 1'b1;
                        r_err_flag <= w_err_next;
                        if (r_cnt == LAST) begin
                            r_beat_ready <= 1'b0;
                            // An errored line skips the array write entirely.
                            if (w_err_next) begin
                                r_done  <= 1'b1;
                                r_err   <= 1'b1;
                                r_state <= DONE;
                            end else begin
                                r_way_req <= 1'b1;
                                r_state   <= WRITE;
                            end
                        end
                    end
                end
                WRITE: begin
                    if (way_gnt_i) begin
                        r_way_req <= 1'b0;
                        r_done    <= 1'b1;
                        r_err     <= r_err_flag;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_refill_ready <= 1'b1;
                    r_state        <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    sargantana_icache_line_buffer #(
        .LB_BEATS  (N),
        .LB_BEAT_W (BEAT_WIDTH),
        .LB_IDX_W  (CNT_W)
    ) u_line_buffer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .we_i   (w_beat_hs),
        .idx_i  (r_cnt),
        .data_i (beat_data_i),
        .line_o (way_data_o)
    );

    assign refill_ready_o = r_refill_ready;
    assign beat_ready_o   = r_beat_ready;
    assign way_req_o      = r_way_req;
    assign way_we_o       = r_way_req;
    assign way_addr_o     = r_idx;
    assign done_o         = r_done;
    assign err_o          = r_err;

`ifdef SARGANTANA_ICACHE_CRITICAL_FWD_EN
    logic [CNT_W-1:0]      r_crit;
    logic                  r_fwd_valid;
    logic [BEAT_WIDTH-1:0] r_fwd_data;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_crit      <= '0;
            r_fwd_valid <= 1'b0;
            r_fwd_data  <= '0;
        end else begin
            r_fwd_valid <= 1'b0;
            if (w_req_hs) begin
                r_crit <= refill_word_i;
            end
            if (w_beat_hs && (r_cnt == r_crit) && !beat_err_i) begin
                r_fwd_valid <= 1'b1;
                r_fwd_data  <= beat_data_i;
            end
        end
    end

    assign fwd_valid_o = r_fwd_valid;
    assign fwd_data_o  = r_fwd_data;
`else
    logic w_unused_word;

    assign w_unused_word = ^refill_word_i;
    assign fwd_valid_o   = 1'b0;
    assign fwd_data_o    = '0;
`endif

endmodule

// File: tb/tb_sargantana_icache_refill.sv
// Scoreboard bench for sargantana_icache_refill; forwarding checks follow SARGANTANA_ICACHE_CRITICAL_FWD_EN.
module tb_sargantana_icache_refill;

    localparam int SW = 256;
    localparam int BW = 64;
    localparam int AW = 7;
    localparam int N  = SW / BW;
    localparam int WW = $clog2(N);

    typedef logic [BW-1:0] beats_t [N];
    typedef logic          errs_t  [N];
    typedef struct { logic [AW-1:0] addr; logic [SW-1:0] data; } wr_t;
    typedef struct { logic [BW-1:0] data; int cyc; } fwd_t;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          refill_valid_i;
    logic          refill_ready_o;
    logic [AW-1:0] refill_idx_i;
    logic [WW-1:0] refill_word_i;
    logic          beat_valid_i;
    logic          beat_ready_o;
    logic [BW-1:0] beat_data_i;
    logic          beat_err_i;
    logic          way_req_o;
    logic          way_we_o;
    logic [AW-1:0] way_addr_o;
    logic [SW-1:0] way_data_o;
    logic          way_gnt_i = 1'b0;
    logic          done_o;
    logic          err_o;
    logic          fwd_valid_o;
    logic [BW-1:0] fwd_data_o;

    sargantana_icache_refill #(
        .SET_WIDHT  (SW),
        .BEAT_WIDTH (BW),
        .ADDR_WIDHT (AW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .refill_valid_i (refill_valid_i),
        .refill_ready_o (refill_ready_o),
        .refill_idx_i   (refill_idx_i),
        .refill_word_i  (refill_word_i),
        .beat_valid_i   (beat_valid_i),
        .beat_ready_o   (beat_ready_o),
        .beat_data_i    (beat_data_i),
        .beat_err_i     (beat_err_i),
        .way_req_o      (way_req_o),
        .way_we_o       (way_we_o),
        .way_addr_o     (way_addr_o),
        .way_data_o     (way_data_o),
        .way_gnt_i      (way_gnt_i),
        .done_o         (done_o),
        .err_o          (err_o),
        .fwd_valid_o    (fwd_valid_o),
        .fwd_data_o     (fwd_data_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   errors = 0;
    int   checks = 0;
    wr_t  wq[$];
    logic dq[$];
    fwd_t fq[$];
    int   last_beat_cyc = 0;
    int   last_gnt_cyc  = 0;
    int   done_cyc      = 0;
    int   done_cnt      = 0;
    int   fwd_exp       = 0;
    int   fwd_seen      = 0;
    int   gnt_delay     = 0;
    bit   gnt_noise     = 1'b0;
    int   req_age       = 0;
    logic prev_req      = 1'b0;

    task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none/other", name);
    endtask

    // Arbiter model: grant after gnt_delay request cycles; random noise while idle.
    always @(posedge clk) begin
        #1;
        if (way_req_o) begin
            req_age++;
            way_gnt_i = (req_age > gnt_delay);
        end else begin
            req_age   = 0;
            way_gnt_i = gnt_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_i) begin
            prev_req = 1'b0;
        end else begin
            if (way_req_o) begin
                if (!prev_req) check("req_start_cycle", cyc, last_beat_cyc + 1);
                if (wq.size() == 0) begin
                    fail("unexpected_write");
                end else begin
                    check("way_we", way_we_o, 1'b1);
                    check("way_addr", way_addr_o, wq[0].addr);
                    check("way_data", way_data_o, wq[0].data);
                    if (way_gnt_i) begin
                        check("req_hold_len", req_age, gnt_delay + 1);
                        last_gnt_cyc = cyc;
                        void'(wq.pop_front());
                    end
                end
            end
            prev_req = way_req_o;
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
                if (dq.size() == 0) begin
                    fail("unexpected_done");
                end else begin
                    logic e;
                    e = dq.pop_front();
                    check("err_o", err_o, e);
                    if (e) check("err_done_cycle", cyc, last_beat_cyc + 1);
                    else   check("done_after_gnt", cyc, last_gnt_cyc + 1);
                end
            end
            if (fwd_valid_o) begin
                fwd_seen++;
                if (fq.size() == 0) begin
                    fail("unexpected_fwd");
                end else begin
                    fwd_t f;
                    f = fq.pop_front();
                    check("fwd_data", fwd_data_o, f.data);
                    check("fwd_cycle", cyc, f.cyc);
                end
            end
        end
    end

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [AW-1:0] idx, input logic [WW-1:0] w, output int t);
        int n = 0;
        refill_valid_i = 1'b1;
        refill_idx_i   = idx;
        refill_word_i  = w;
        while (!refill_ready_o && n < 50) begin
            wait_edge();
            n++;
        end
        if (!refill_ready_o) fail("req_timeout");
        t = cyc;
        wait_edge();
        refill_valid_i = 1'b0;
        refill_idx_i   = AW'($urandom);
        refill_word_i  = WW'($urandom);
    endtask

    task automatic send_beat(input logic [BW-1:0] d, input logic e, output int acc);
        int n = 0;
        beat_valid_i = 1'b1;
        beat_data_i  = d;
        beat_err_i   = e;
        while (!beat_ready_o && n < 50) begin
            wait_edge();
            n++;
        end
        if (!beat_ready_o) fail("beat_timeout");
        acc = cyc;
        wait_edge();
        beat_valid_i = 1'b0;
        beat_data_i  = {$urandom, $urandom};
        beat_err_i   = 1'($urandom_range(0, 1));
    endtask

    task automatic refill(input logic [AW-1:0] idx, input logic [WW-1:0] w, input beats_t b,
                          input errs_t e, input int gap_at, input int gap_len, input int dly,
                          output int t);
        logic [SW-1:0] line = '0;
        logic          anye = 1'b0;
        int            acc  = 0;
        int            d0   = done_cnt;
        int            n    = 0;
        wr_t           wr;
        for (int k = 0; k < N; k++) begin
            line = line | (SW'(b[k]) << (k * BW));
            anye = anye | e[k];
        end
        gnt_delay = dly;
        if (!anye) begin
            wr.addr = idx;
            wr.data = line;
            wq.push_back(wr);
        end
        dq.push_back(anye);
        send_req(idx, w, t);
        for (int k = 0; k < N; k++) begin
            if (k == gap_at) repeat (gap_len) wait_edge();
            send_beat(b[k], e[k], acc);
`ifdef SARGANTANA_ICACHE_CRITICAL_FWD_EN
            if (k == int'(w) && !e[k]) begin
                fwd_t f;
                f.data = b[k];
                f.cyc  = acc + 1;
                fq.push_back(f);
                fwd_exp++;
            end
`endif
            if (k == N - 1) last_beat_cyc = acc;
        end
        while (done_cnt == d0 && n < 200) begin
            wait_edge();
            n++;
        end
        if (done_cnt == d0) fail("done_timeout");
    endtask

    initial begin
        beats_t b;
        errs_t  e;
        int     t;
        int     acc;
        rst_i          = 1'b1;
        refill_valid_i = 1'b0;
        refill_idx_i   = '0;
        refill_word_i  = '0;
        beat_valid_i   = 1'b0;
        beat_data_i    = '0;
        beat_err_i     = 1'b0;

        repeat (3) wait_edge();
        check("rst_refill_ready", refill_ready_o, 1'b0);
        check("rst_beat_ready", beat_ready_o, 1'b0);
        check("rst_way_req", way_req_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_way_addr", way_addr_o, '0);
        check("rst_way_data", way_data_o, '0);
        check("rst_fwd_valid", fwd_valid_o, 1'b0);
        rst_i = 1'b0;
        wait_edge();
        check("post_rst_ready", refill_ready_o, 1'b1);

        for (int k = 0; k < N; k++) begin
            b[k] = {16{4'(k + 1)}};
            e[k] = 1'b0;
        end
        refill(7'h15, WW'(2), b, e, -1, 0, 0, t);
        check("basic_done_cycle", done_cyc, t + 6);

        refill(7'h15, WW'(2), b, e, -1, 0, 5, t);
        check("held_done_cycle", done_cyc, t + 11);

        for (int k = 0; k < N; k++) b[k] = {$urandom, $urandom};
        refill(7'h2A, WW'(1), b, e, 2, 3, 1, t);
        check("bursty_done_cycle", done_cyc, t + 10);

        e[2] = 1'b1;
        refill(7'h0C, WW'(2), b, e, -1, 0, 0, t);
        check("err_done_cycle_abs", done_cyc, t + 5);
        e[2] = 1'b0;

        send_req(7'h33, WW'(0), t);
        send_beat(64'hDEAD_BEEF_0000_0000, 1'b0, acc);
        send_beat(64'hDEAD_BEEF_0000_0001, 1'b0, acc);
        rst_i = 1'b1;
        wait_edge();
        rst_i = 1'b0;
        check("abort_beat_ready", beat_ready_o, 1'b0);
        check("abort_way_data", way_data_o, '0);
        repeat (4) wait_edge();
        for (int k = 0; k < N; k++) b[k] = {$urandom, $urandom};
        refill(7'h7F, WW'(3), b, e, -1, 0, 0, t);
        check("after_abort_done_cycle", done_cyc, t + 6);

        gnt_noise = 1'b1;
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < N; k++) begin
                b[k] = {$urandom, $urandom};
                e[k] = ($urandom_range(0, 9) == 0);
            end
            refill(AW'($urandom), WW'($urandom), b, e, $urandom_range(0, N - 1),
                   $urandom_range(0, 3), $urandom_range(0, 3), t);
        end

        repeat (5) wait_edge();
        check("writes_outstanding", wq.size(), 0);
        check("dones_outstanding", dq.size(), 0);
        check("fwds_outstanding", fq.size(), 0);
        check("fwd_count", fwd_seen, fwd_exp);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
